// File: rtl/glitch_pkg.sv
// Shared types and default constants for the glitch injector / detector pair.
package glitch_pkg;

    localparam int GLITCH_WIDTH = 8;
    localparam logic [GLITCH_WIDTH-1:0] GLITCH_PATTERN = 8'b10101010;

    typedef enum logic [1:0] {
        DET_OK      = 2'd0,
        DET_SUSPECT = 2'd1,
        DET_FAULT   = 2'd2
    } det_state_t;

endpackage

// File: rtl/glitch_detector_sat_counter.sv
// Saturating up-counter with synchronous reset and clear; holds at all-ones.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/glitch_detector.sv
// Compares a possibly-glitched word against its clean copy and latches a sticky fault
// after THRESHOLD consecutive mismatches. Optional capture outputs: GLITCH_DETECTOR_CAPTURE_EN.
module glitch_detector
    import glitch_pkg::*;
#(
    parameter int WIDTH     = GLITCH_WIDTH,
    parameter int THRESHOLD = 3,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 clear,
    output logic                 mismatch,
    output logic                 fault,
    output logic [1:0]           state,
    output logic [CNT_WIDTH-1:0] mismatch_count
`ifdef GLITCH_DETECTOR_CAPTURE_EN
    ,
    output logic [WIDTH-1:0]     cap_a,
    output logic [WIDTH-1:0]     cap_b,
    output logic [WIDTH-1:0]     cap_syndrome,
    output logic                 cap_valid
`endif
);

    localparam int SW = $clog2(THRESHOLD + 1);
    localparam logic [SW-1:0] THR = SW'(THRESHOLD);

    det_state_t    state_q, state_d;
    logic [SW-1:0] streak_q, streak_d;
    logic [SW-1:0] streak_inc;
    logic [WIDTH-1:0] diff;
    logic          hit;
    logic          enter_fault;

    assign diff       = in_a ^ in_b;
    assign hit        = valid && (diff != '0);
    assign streak_inc = streak_q + SW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= DET_OK;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
        end
    end

    // Invalid cycles fall through every branch untouched, so gaps never break a streak.
    always_comb begin
        state_d  = state_q;
        streak_d = streak_q;
        if (clear) begin
            state_d  = DET_OK;
            streak_d = '0;
        end else begin
            case (state_q)
                DET_OK: begin
                    if (hit) begin
                        streak_d = SW'(1);
                        state_d  = (THRESHOLD == 1) ? DET_FAULT : DET_SUSPECT;
                    end
                end
                DET_SUSPECT: begin
                    if (valid) begin
                        if (hit) begin
                            streak_d = streak_inc;
                            if (streak_inc == THR) begin
                                state_d = DET_FAULT;
                            end
                        end else begin
                            streak_d = '0;
                            state_d  = DET_OK;
                        end
                    end
                end
                DET_FAULT: begin
                    state_d = DET_FAULT;
                end
                default: begin
                    state_d  = DET_OK;
                    streak_d = '0;
                end
            endcase
        end
    end

    assign enter_fault = (state_q != DET_FAULT) && (state_d == DET_FAULT);

    always_ff @(posedge clk) begin
        if (reset) begin
            mismatch <= 1'b0;
        end else begin
            mismatch <= hit && !clear;
        end
    end

    assign state = state_q;
    assign fault = (state_q == DET_FAULT);

    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_mismatch_count (
        .clk   (clk),
        .reset (reset),
        .clr   (clear),
        .inc   (hit && !clear),
        .count (mismatch_count)
    );

`ifdef GLITCH_DETECTOR_CAPTURE_EN
    // Only the sample that tripped the fault is kept; later samples in FAULT do not overwrite it.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cap_a        <= '0;
            cap_b        <= '0;
            cap_syndrome <= '0;
            cap_valid    <= 1'b0;
        end else if (enter_fault) begin
            cap_a        <= in_a;
            cap_b        <= in_b;
            cap_syndrome <= diff;
            cap_valid    <= 1'b1;
        end
    end
`else
    logic unused_enter_fault;
    assign unused_enter_fault = enter_fault;
`endif

endmodule

// File: tb/tb_glitch_detector.sv
// Directed-vector scoreboard bench for glitch_detector (THRESHOLD=3, plus a CNT_WIDTH=4 copy).
module tb_glitch_detector;
    import glitch_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1;
    logic       valid = 1'b0;
    logic       clear = 1'b0;
    logic [7:0] in_a  = 8'h00;
    logic [7:0] in_b  = 8'h00;

    logic        mismatch, fault;
    logic [1:0]  state;
    logic [15:0] mismatch_count;
    logic        mismatch4, fault4;
    logic [1:0]  state4;
    logic [3:0]  mismatch_count4;
`ifdef GLITCH_DETECTOR_CAPTURE_EN
    logic [7:0] cap_a, cap_b, cap_syndrome;
    logic       cap_valid;
    logic [7:0] cap_a4, cap_b4, cap_syndrome4;
    logic       cap_valid4;
`endif

    glitch_detector #(.WIDTH(8), .THRESHOLD(3), .CNT_WIDTH(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .valid          (valid),
        .in_a           (in_a),
        .in_b           (in_b),
        .clear          (clear),
        .mismatch       (mismatch),
        .fault          (fault),
        .state          (state),
        .mismatch_count (mismatch_count)
`ifdef GLITCH_DETECTOR_CAPTURE_EN
        ,
        .cap_a          (cap_a),
        .cap_b          (cap_b),
        .cap_syndrome   (cap_syndrome),
        .cap_valid      (cap_valid)
`endif
    );

    glitch_detector #(.WIDTH(8), .THRESHOLD(3), .CNT_WIDTH(4)) dut4 (
        .clk            (clk),
        .reset          (reset),
        .valid          (valid),
        .in_a           (in_a),
        .in_b           (in_b),
        .clear          (clear),
        .mismatch       (mismatch4),
        .fault          (fault4),
        .state          (state4),
        .mismatch_count (mismatch_count4)
`ifdef GLITCH_DETECTOR_CAPTURE_EN
        ,
        .cap_a          (cap_a4),
        .cap_b          (cap_b4),
        .cap_syndrome   (cap_syndrome4),
        .cap_valid      (cap_valid4)
`endif
    );

    // Expected word: [31] mismatch, [30:29] state, [28:13] count, [12:9] 4-bit count, [8:0] {cap_valid, cap_syndrome}
    logic [31:0] exp_q[$];
    int n_vec  = 0;
    int n_miss = 0;

    task automatic step(input logic rst, input logic clr, input logic v,
                        input logic [7:0] a, input logic [7:0] b,
                        input logic e_mis, input logic [1:0] e_st, input int cnt,
                        input logic [8:0] cap);
        logic [3:0] c4;
        @(negedge clk);
        reset = rst;
        clear = clr;
        valid = v;
        in_a  = a;
        in_b  = b;
        @(posedge clk);
        #1;
        c4 = (cnt > 15) ? 4'hF : cnt[3:0];
        exp_q.push_back({e_mis, e_st, cnt[15:0], c4, cap});
    endtask

    always @(negedge clk) begin : monitor
        logic [31:0] e;
        logic        bad;
        logic        e_fault;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            bad = 1'b0;
            n_vec++;
            e_fault = (e[30:29] == 2'd2);
            if (mismatch !== e[31]) begin
                $display("FAIL mismatch vec %0d: got %0b want %0b", n_vec, mismatch, e[31]);
                bad = 1'b1;
            end
            if (state !== e[30:29]) begin
                $display("FAIL state vec %0d: got %0d want %0d", n_vec, state, e[30:29]);
                bad = 1'b1;
            end
            if (fault !== e_fault) begin
                $display("FAIL fault vec %0d: got %0b want %0b", n_vec, fault, e_fault);
                bad = 1'b1;
            end
            if (mismatch_count !== e[28:13]) begin
                $display("FAIL count vec %0d: got %0d want %0d", n_vec, mismatch_count, e[28:13]);
                bad = 1'b1;
            end
            if (mismatch_count4 !== e[12:9]) begin
                $display("FAIL count4 vec %0d: got %0d want %0d", n_vec, mismatch_count4, e[12:9]);
                bad = 1'b1;
            end
            if (state4 !== e[30:29] || fault4 !== e_fault || mismatch4 !== e[31]) begin
                $display("FAIL dut4_flags vec %0d: got st=%0d f=%0b m=%0b want st=%0d f=%0b m=%0b",
                         n_vec, state4, fault4, mismatch4, e[30:29], e_fault, e[31]);
                bad = 1'b1;
            end
`ifdef GLITCH_DETECTOR_CAPTURE_EN
            if ({cap_valid, cap_syndrome} !== e[8:0]) begin
                $display("FAIL capture vec %0d: got %h want %h", n_vec, {cap_valid, cap_syndrome}, e[8:0]);
                bad = 1'b1;
            end
`endif
            if (bad) n_miss++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held two cycles
        step(1, 0, 0, 8'h00, 8'h00, 0, DET_OK, 0, 9'h000);
        step(1, 0, 0, 8'h00, 8'h00, 0, DET_OK, 0, 9'h000);
        // Matching samples
        for (int i = 0; i < 10; i++)
            step(0, 0, 1, 8'hAA, 8'hAA, 0, DET_OK, 0, 9'h000);
        // Three consecutive mismatches -> FAULT
        step(0, 0, 1, 8'h55, 8'hAA, 1, DET_SUSPECT, 1, 9'h000);
        step(0, 0, 1, 8'h55, 8'hAA, 1, DET_SUSPECT, 2, 9'h000);
        step(0, 0, 1, 8'h55, 8'hAA, 1, DET_FAULT,   3, 9'h1FF);
        // FAULT is sticky; invalid differing inputs are ignored
        step(0, 0, 1, 8'hAA, 8'hAA, 0, DET_FAULT, 3, 9'h1FF);
        step(0, 0, 0, 8'h33, 8'hCC, 0, DET_FAULT, 3, 9'h1FF);
        // clear beats a same-cycle mismatch
        step(0, 1, 1, 8'h55, 8'hAA, 0, DET_OK, 0, 9'h000);
        // mm, mm, match, mm, mm -> ends in SUSPECT
        step(0, 0, 1, 8'h55, 8'hAA, 1, DET_SUSPECT, 1, 9'h000);
        step(0, 0, 1, 8'h55, 8'hAA, 1, DET_SUSPECT, 2, 9'h000);
        step(0, 0, 1, 8'h3C, 8'h3C, 0, DET_OK,      2, 9'h000);
        step(0, 0, 1, 8'h01, 8'h00, 1, DET_SUSPECT, 3, 9'h000);
        step(0, 0, 1, 8'h80, 8'h00, 1, DET_SUSPECT, 4, 9'h000);
        // Reset mid-SUSPECT beats a mismatching sample
        step(1, 0, 1, 8'h55, 8'hAA, 0, DET_OK, 0, 9'h000);
        // Gaps do not break the streak
        step(0, 0, 1, 8'h0F, 8'h00, 1, DET_SUSPECT, 1, 9'h000);
        for (int i = 0; i < 5; i++)
            step(0, 0, 0, 8'hFF, 8'h00, 0, DET_SUSPECT, 1, 9'h000);
        step(0, 0, 1, 8'h0F, 8'h00, 1, DET_SUSPECT, 2, 9'h000);
        step(0, 0, 1, 8'h0F, 8'h00, 1, DET_FAULT,   3, 9'h10F);
        // Reset beats clear and valid while in FAULT
        step(1, 1, 1, 8'h55, 8'hAA, 0, DET_OK, 0, 9'h000);
        // 20 mismatches: 16-bit count reaches 20, 4-bit count saturates at 15
        for (int i = 1; i <= 20; i++)
            step(0, 0, 1, 8'h55, 8'hAA, 1, (i < 3) ? DET_SUSPECT : DET_FAULT, i,
                 (i < 3) ? 9'h000 : 9'h1FF);
        step(0, 1, 1, 8'h55, 8'hAA, 0, DET_OK, 0, 9'h000);
        step(0, 0, 0, 8'h00, 8'h00, 0, DET_OK, 0, 9'h000);

        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
            n_miss++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/glitch_detector.md
# glitch_detector

Downstream consumer of the glitch injector in the dual-core glitch-protection path. Compares the possibly-glitched word (`in_a`, taken from the injector output) against the redundant clean copy (`in_b`) on every valid sample. Declares a sticky fault after `THRESHOLD` consecutive mismatching samples. Keeps a saturating total-mismatch count for the bench and for the core-level fault handler.

## Interface
- `WIDTH`, 8: compared word width.
- `THRESHOLD`, 3: consecutive mismatching valid samples needed to enter FAULT; legal range 1..255.
- `CNT_WIDTH`, 16: width of the total-mismatch counter.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `valid`  in  1  `in_a`/`in_b` hold a sample this cycle.
- `in_a`  in  WIDTH  word under test, from the glitch injector `out`.
- `in_b`  in  WIDTH  redundant reference word.
- `clear`  in  1  returns the FSM to OK and zeroes the counters.
- `mismatch`  out  1  registered one-cycle pulse per mismatching valid sample.
- `fault`  out  1  sticky; high while the state is FAULT.
- `state`  out  2  current FSM state (`det_state_t`).
- `mismatch_count`  out  CNT_WIDTH  saturating total of mismatching valid samples.

## Operation
- Sample compare: `diff = in_a ^ in_b`. A sample is a mismatch when `valid` is high and `diff` is non-zero. When `valid` is low, the inputs are ignored.
- `streak` is an internal consecutive-mismatch counter, `$clog2(THRESHOLD+1)` bits wide.
- FSM states: `DET_OK`=0, `DET_SUSPECT`=1, `DET_FAULT`=2. Encoding 3 is illegal and recovers to `DET_OK`.
  - OK, mismatch: `streak`=1. Go to FAULT if `THRESHOLD`==1, otherwise go to SUSPECT.
  - SUSPECT, matching valid sample: `streak`=0, go to OK.
  - SUSPECT, mismatch: `streak`++. Go to FAULT when the new value equals `THRESHOLD`.
  - SUSPECT, no valid: hold state and `streak`. Gaps do not break a streak.
  - FAULT: hold until `clear`. Samples are still compared, and `mismatch` and `mismatch_count` keep updating.
- `clear`: next state OK, `streak`=0, `mismatch_count`=0, `mismatch`=0.
  - `clear` has priority over a same-cycle `valid`; that sample is discarded entirely.
- `reset`: `state`=OK, `fault`=0, `mismatch`=0, `mismatch_count`=0, `streak`=0. Capture registers are 0 when the capture feature is compiled in.
  - `reset` has priority over `clear` and `valid`.
- `mismatch_count` saturates at all-ones; further mismatches leave it unchanged.

## Timing
- All outputs are registered. Latency is 1 cycle.
  - A sample presented at edge N is reflected in `mismatch`, `mismatch_count`, `state` and `fault` after edge N.
- `fault` rises one cycle after the edge that samples the `THRESHOLD`-th consecutive mismatch.
- `fault` falls one cycle after the edge where `clear` is sampled high.
- No backpressure: the block accepts a sample every cycle.
- Reset applied mid-streak or in FAULT takes effect at the next edge, with no partial state kept.

## Configuration
- Macro `GLITCH_DETECTOR_CAPTURE_EN`.
- Defined: adds these outputs:
  - `cap_a` (WIDTH), `cap_b` (WIDTH), `cap_syndrome` (WIDTH): hold `in_a`, `in_b` and `diff` of the sample that caused the OK/SUSPECT-to-FAULT transition. They are frozen until `clear` or `reset`, which zero them.
  - `cap_valid` (1): high while the capture registers hold data.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

## Structure
- Shared package `glitch_pkg` holds:
  - `typedef enum logic [1:0] det_state_t {DET_OK, DET_SUSPECT, DET_FAULT}`.
  - The default constants `GLITCH_WIDTH`=8 and `GLITCH_PATTERN`=8'b10101010, also used by the injector bench.
- One sub-module, `sat_counter` (params `WIDTH`; ports `clk`, `reset`, `clr`, `inc`, `count`), instantiated for `mismatch_count`.
- `streak` stays inline in the FSM.

## Test plan
Setup: `WIDTH`=8, `THRESHOLD`=3.
1. Reset held 2 cycles, then `valid`=1 with `in_a`=`in_b`=8'hAA for 10 cycles → `mismatch`=0, `state`=OK, `mismatch_count`=0 throughout.
2. `in_a`=8'h55, `in_b`=8'hAA for 3 consecutive valid cycles → `mismatch` high for 3 cycles, `state` goes SUSPECT then FAULT, `fault`=1 one cycle after the 3rd sample, `mismatch_count`=3. With capture compiled in: `cap_syndrome`=8'hFF.
3. Sequence mismatch, mismatch, match, mismatch, mismatch → never reaches FAULT, `mismatch_count`=4, final `state`=SUSPECT.
4. Sequence mismatch, `valid`=0 for 5 cycles, mismatch, mismatch → FAULT reached, because gaps do not reset the streak.
5. In FAULT, drive `clear`=1 together with a mismatching valid sample → next cycle `state`=OK, `fault`=0, `mismatch_count`=0, `mismatch`=0. Also assert `reset` mid-SUSPECT → all outputs 0 next cycle.
6. `CNT_WIDTH`=4, 20 mismatching samples → `mismatch_count` saturates at 4'hF while `fault` stays 1.
